alu_cmd_sequencer: RTL and testbench

Command-side front end for the 4-bit combinational ALU.
- Accepts operation commands (A, B, Sel) over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU's A/B/Sel inputs from registers and captures the 5-bit ALU result one cycle later.
- Returns each result with its opcode over a valid/ready response interface.
- Sits between a bus/UART command decoder and the ALU core.

---
 rtl/alu_cmd_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + sequencer that drives a 4-bit combinational ALU and returns each result over valid/ready.
// Optional reference checker enabled by defining ALU_CMD_SEQUENCER_SELFCHECK_EN (adds rsp_mismatch).
module alu_cmd_sequencer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [4:0]  DIV0_VALUE = 5'b11111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [4:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_data,
  output logic [3:0] rsp_sel,
  output logic       rsp_div0,
  output logic       busy
`ifdef ALU_CMD_SEQUENCER_SELFCHECK_EN
  ,
  output logic       rsp_mismatch
`endif
);

  // Both interfaces: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holds valid and its payload stable until that edge.

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [11:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic        push, pop;
  logic        capture, release_rsp;
  logic        init_done;
  logic [3:0]  head_a, head_b, head_sel;
  logic        div0;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // init_done keeps cmd_ready low for the first cycle after reset release
  assign cmd_ready = init_done & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE) | ~empty;

  assign {head_sel, head_a, head_b} = mem[rd_ptr[AW-1:0]];
  assign div0 = (alu_sel == 4'b0011) && (alu_b == 4'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd_sel, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          release_rsp = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
      alu_sel  <= 4'd0;
    end else if (pop) begin
      alu_a    <= head_a;
      alu_b    <= head_b;
      alu_sel  <= head_sel;
    end
  end

  // Response registers stay put until the handshake; data is not cleared on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 5'd0;
      rsp_sel   <= 4'd0;
      rsp_div0  <= 1'b0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= div0 ? DIV0_VALUE : alu_out;
      rsp_sel   <= alu_sel;
      rsp_div0  <= div0;
    end else if (release_rsp) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_CMD_SEQUENCER_SELFCHECK_EN
  function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] sel);
    logic [4:0] ea, eb, r;
    ea = {1'b0, a};
    eb = {1'b0, b};
    case (sel)
      4'd0:    r = ea + eb;
      4'd1:    r = ea - eb;
      4'd2:    r = ea * eb;
      4'd3:    r = (eb == 5'd0) ? 5'd0 : ea / eb;
      4'd4:    r = {a, 1'b0};
      4'd5:    r = {2'b00, a[3:1]};
      4'd6:    r = {1'b0, a[2:0], a[3]};
      4'd7:    r = {1'b0, a[0], a[3:1]};
      4'd8:    r = ea & eb;
      4'd9:    r = ea | eb;
      4'd10:   r = ea ^ eb;
      4'd11:   r = ~(ea | eb);
      4'd12:   r = ~(ea & eb);
      4'd13:   r = ~(ea ^ eb);
      4'd14:   r = {4'd0, (a > b)};
      default: r = {4'd0, (a == b)};
    endcase
    return r;
  endfunction

  logic [4:0] ref_out;
  assign ref_out = ref_alu(alu_a, alu_b, alu_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_mismatch <= 1'b0;
    end else if (capture) begin
      rsp_mismatch <= ~div0 && (ref_out != alu_out);
    end else if (release_rsp) begin
      rsp_mismatch <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized + directed bench for alu_cmd_sequencer with an ALU stub and queue-based scoreboard.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = 4'd0, cmd_b = 4'd0, cmd_sel = 4'd0;
  logic [3:0] alu_a, alu_b, alu_sel;
  logic [4:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [4:0] rsp_data;
  logic [3:0] rsp_sel;
  logic       rsp_div0;
  logic       busy;
  logic [4:0] wrong_mask = 5'd0;
  logic       mm_act;
`ifdef ALU_CMD_SEQUENCER_SELFCHECK_EN
  logic       rsp_mismatch;
  assign mm_act = rsp_mismatch;
`else
  assign mm_act = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [10:0] exp_q [$];
  logic [10:0] rsp_log [$];
  int          hs_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU behaviour from the opcode table, on plain integers
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] sel);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (sel)
      4'd0:    r = ia + ib;
      4'd1:    r = ia - ib;
      4'd2:    r = ia * ib;
      4'd3:    r = (ib == 0) ? 0 : ia / ib;
      4'd4:    r = ia * 2;
      4'd5:    r = ia / 2;
      4'd6:    r = ((ia * 2) % 16) + (ia / 8);
      4'd7:    r = (ia / 2) + ((ia % 2) * 8);
      4'd8:    r = ia & ib;
      4'd9:    r = ia | ib;
      4'd10:   r = ia ^ ib;
      4'd11:   r = ~(ia | ib);
      4'd12:   r = ~(ia & ib);
      4'd13:   r = ~(ia ^ ib);
      4'd14:   r = (ia > ib) ? 1 : 0;
      default: r = (ia == ib) ? 1 : 0;
    endcase
    return r[4:0];
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_sel) ^ wrong_mask;

  // Expected response: {mismatch, div0, sel, data}
  function automatic logic [10:0] expect_of(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] sel);
    if (sel == 4'd3 && b == 4'd0) return {1'b0, 1'b1, sel, 5'b11111};
    return {(wrong_mask != 5'd0), 1'b0, sel, alu_fn(a, b, sel) ^ wrong_mask};
  endfunction

  alu_cmd_sequencer #(.FIFO_DEPTH(4), .DIV0_VALUE(5'b11111)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_sel(rsp_sel), .rsp_div0(rsp_div0),
    .busy(busy)
`ifdef ALU_CMD_SEQUENCER_SELFCHECK_EN
    , .rsp_mismatch(rsp_mismatch)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: called at posedge+1, returns at posedge+1 after the accepting edge
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    bit done = 1'b0;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back(expect_of(a, b, sel));
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (done) break;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL push_timeout: cmd_ready stayed 0, expected 1");
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks hold stability
  initial begin
    logic        prev_hold = 1'b0;
    logic [10:0] prev_rsp = '0;
    logic [10:0] cur, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        continue;
      end
      cur = {mm_act, rsp_div0, rsp_sel, rsp_data};
      if (prev_hold) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_payload", 32'(cur), 32'(prev_rsp));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got 0x%0h expected no response", cur);
        end else begin
          e = exp_q.pop_front();
          check("rsp_order", 32'(cur), 32'(e));
        end
        rsp_log.push_back(cur);
        hs_cyc.push_back(cyc);
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = cur;
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n0;
    bit seen;
    bit rand_done;

    // Reset state
    #12;
    check("reset_outputs", 32'({cmd_ready, rsp_valid, busy, alu_a, alu_b, alu_sel,
                                rsp_data, rsp_sel, rsp_div0, mm_act}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_first_cycle", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // Single add, latency
    rsp_ready = 1'b1;
    push(4'd9, 4'd5, 4'd0);
    @(negedge clk);
    @(negedge clk);
    check("latency_n1_valid", 32'(rsp_valid), 32'd0);
    check("alu_inputs_loaded", 32'({alu_sel, alu_a, alu_b}), 32'h095);
    @(negedge clk);
    check("latency_n2_valid", 32'(rsp_valid), 32'd1);
    drain();
    check("add_9_5", 32'(rsp_log[rsp_log.size()-1]), 32'({1'b0, 1'b0, 4'd0, 5'd14}));

    // Divide by zero, then a normal divide
    push(4'd7, 4'd0, 4'd3);
    drain();
    check("div_by_zero", 32'(rsp_log[rsp_log.size()-1]), 32'({1'b0, 1'b1, 4'd3, 5'b11111}));
    push(4'd12, 4'd3, 4'd3);
    drain();
    check("div_12_3", 32'(rsp_log[rsp_log.size()-1]), 32'({1'b0, 1'b0, 4'd3, 5'd4}));
    check("alu_hold_between", 32'({alu_sel, alu_a, alu_b}), 32'h3c3);

    // Fill: one in the FSM plus four queued
    rsp_ready = 1'b0;
    n0 = rsp_log.size();
    for (int i = 0; i < 5; i++) push(4'(i + 1), 4'(i + 2), 4'(i + 8));
    @(negedge clk);
    check("cmd_ready_full", 32'(cmd_ready), 32'd0);
    check("busy_full", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("cmd_ready_before_pop", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("cmd_ready_after_pop", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    drain();
    check("fill_rsp_count", 32'(rsp_log.size() - n0), 32'd5);

    // Back-to-back commands
    n0 = rsp_log.size();
    push(4'd3, 4'd5, 4'd1);
    push(4'b1001, 4'd0, 4'd6);
    drain();
    check("b2b_sub", 32'(rsp_log[n0]), 32'({1'b0, 1'b0, 4'd1, 5'b11110}));
    check("b2b_rotl", 32'(rsp_log[n0+1]), 32'({1'b0, 1'b0, 4'd6, 5'b00011}));
    check("b2b_spacing", 32'(hs_cyc[n0+1] - hs_cyc[n0]), 32'd2);
    check("idle_after_drain", 32'(busy), 32'd0);

    // Reset while a response is pending with two queued
    rsp_ready = 1'b0;
    push(4'd1, 4'd1, 4'd0);
    push(4'd2, 4'd2, 4'd0);
    push(4'd3, 4'd3, 4'd0);
    check("resp_pending", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_valid", 32'(rsp_valid), 32'd0);
    check("reset_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("no_stale_rsp", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [3:0] rb;
          rb = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          push(4'($urandom_range(0, 15)), rb, 4'($urandom_range(0, 15)));
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    drain();

`ifdef ALU_CMD_SEQUENCER_SELFCHECK_EN
    wrong_mask = 5'b00100;
    push(4'd6, 4'd6, 4'd15);
    drain();
    check("mismatch_flagged", 32'(rsp_log[rsp_log.size()-1]), 32'({1'b1, 1'b0, 4'd15, 5'd5}));
    wrong_mask = 5'd0;
    push(4'd6, 4'd6, 4'd15);
    drain();
    check("mismatch_clear", 32'(rsp_log[rsp_log.size()-1]), 32'({1'b0, 1'b0, 4'd15, 5'd1}));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
